// File: rtl/scene_pkg.sv
// Shared definitions for the black-hole demo scene sequencer and renderer.
// Holds the state encoding, speed mapping and default text geometry.
package scene_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_FALL  = 2'd1,
        ST_FLASH = 2'd2,
        ST_DARK  = 2'd3
    } scene_state_e;

    localparam int unsigned DEF_TEXT_Y_START = 20;
    localparam int unsigned DEF_TEXT_Y_END   = 123;

    // Ring texture phase increment per advance; speed 3 freezes the ring
    function automatic logic [7:0] speed_inc(input logic [1:0] speed);
        case (speed)
            2'd0:    speed_inc = 8'd1;
            2'd1:    speed_inc = 8'd2;
            2'd2:    speed_inc = 8'd4;
            default: speed_inc = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/vsync_edge.sv
// Registered vsync rising-edge detector producing a one-cycle frame pulse.
// vsync_q resets high so a vsync already high out of reset never ticks.
module vsync_edge (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    output logic frame_tick
);

    logic vsync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q    <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vsync_q    <= vsync;
            frame_tick <= vsync & ~vsync_q;
        end
    end

endmodule

// File: rtl/scene_sequencer.sv
// Frame-rate scene controller: HOLD -> FALL -> FLASH -> DARK -> HOLD.
// Advances once per frame tick, with pause, single-step and ring-speed control.
module scene_sequencer
    import scene_pkg::*;
#(
    parameter int unsigned TEXT_Y_START = DEF_TEXT_Y_START,
    parameter int unsigned TEXT_Y_END   = DEF_TEXT_Y_END,
    parameter int unsigned FALL_STEP    = 2,
    parameter int unsigned HOLD_FRAMES  = 120,
    parameter int unsigned FLASH_FRAMES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic        pause,
    input  logic        step,
    input  logic [1:0]  speed,
    output logic        frame_tick,
    output logic [15:0] frame_cnt,
    output logic [7:0]  ring_phase,
    output logic [9:0]  text_y,
    output logic        text_en,
    output logic        flash,
    output logic [1:0]  state
);

    localparam logic [9:0]  Y_START    = 10'(TEXT_Y_START);
    localparam logic [10:0] Y_END      = 11'(TEXT_Y_END);
    localparam logic [10:0] Y_STEP     = 11'(FALL_STEP);
    localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_FRAMES - 1);
    localparam logic [7:0]  FLASH_LAST = 8'(FLASH_FRAMES - 1);

    scene_state_e state_q, state_d;
    logic [7:0]   dwell_q, dwell_d;
    logic [9:0]   text_y_d;
    logic [10:0]  fall_sum;
    logic         step_pending;
    logic         adv;

    vsync_edge u_vsync_edge (
        .clk        (clk),
        .reset      (reset),
        .vsync      (vsync),
        .frame_tick (frame_tick)
    );

    assign adv      = frame_tick & (~pause | step | step_pending);
    assign fall_sum = {1'b0, text_y} + Y_STEP;
    assign state    = state_q;

    always_comb begin
        state_d  = state_q;
        dwell_d  = dwell_q;
        text_y_d = text_y;
        if (adv) begin
            case (state_q)
                ST_HOLD: begin
                    text_y_d = Y_START;
                    if (dwell_q == HOLD_LAST) begin
                        state_d = ST_FALL;
                        dwell_d = '0;
                    end else begin
                        dwell_d = dwell_q + 8'd1;
                    end
                end
                ST_FALL: begin
                    // 11-bit sum so a large step near the end cannot wrap past the clamp
                    if (fall_sum >= Y_END) begin
                        text_y_d = Y_END[9:0];
                        state_d  = ST_FLASH;
                        dwell_d  = '0;
                    end else begin
                        text_y_d = fall_sum[9:0];
                    end
                end
                ST_FLASH: begin
                    if (dwell_q == FLASH_LAST) begin
                        state_d = ST_DARK;
                        dwell_d = '0;
                    end else begin
                        dwell_d = dwell_q + 8'd1;
                    end
                end
                default: begin
                    if (dwell_q == HOLD_LAST) begin
                        state_d  = ST_HOLD;
                        dwell_d  = '0;
                        text_y_d = Y_START;
                    end else begin
                        dwell_d = dwell_q + 8'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_HOLD;
            dwell_q      <= '0;
            text_y       <= Y_START;
            text_en      <= 1'b1;
            flash        <= 1'b0;
            frame_cnt    <= '0;
            ring_phase   <= '0;
            step_pending <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            text_y  <= text_y_d;
            text_en <= (state_d == ST_HOLD) || (state_d == ST_FALL);
            flash   <= (state_d == ST_FLASH);
            if (frame_tick)
                step_pending <= 1'b0;
            else if (step)
                step_pending <= 1'b1;
            if (adv) begin
                frame_cnt  <= frame_cnt + 16'd1;
                ring_phase <= ring_phase + speed_inc(speed);
            end
        end
    end

endmodule

// File: tb/tb_scene_sequencer.sv
// Directed self-checking bench for scene_sequencer with a short scene geometry.
module tb_scene_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vsync = 1'b1;
    logic        pause = 1'b0;
    logic        step = 1'b0;
    logic [1:0]  speed = 2'd0;
    logic        frame_tick;
    logic [15:0] frame_cnt;
    logic [7:0]  ring_phase;
    logic [9:0]  text_y;
    logic        text_en;
    logic        flash;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;
    int tick_count = 0;
    int wide_ticks = 0;
    bit prev_tick = 0;

    scene_sequencer #(
        .TEXT_Y_START (20),
        .TEXT_Y_END   (25),
        .FALL_STEP    (2),
        .HOLD_FRAMES  (4),
        .FLASH_FRAMES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .vsync      (vsync),
        .pause      (pause),
        .step       (step),
        .speed      (speed),
        .frame_tick (frame_tick),
        .frame_cnt  (frame_cnt),
        .ring_phase (ring_phase),
        .text_y     (text_y),
        .text_en    (text_en),
        .flash      (flash),
        .state      (state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_tick) tick_count++;
        if (frame_tick && prev_tick) wide_ticks++;
        prev_tick = frame_tick;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; vsync = 1'b1; pause = 1'b0; step = 1'b0; speed = 2'd0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One vsync low->high frame; returns at the negedge after the advance edge
    task automatic frame(input bit step_on_tick);
        bit seen = 0;
        @(negedge clk) vsync = 1'b0;
        repeat (3) @(negedge clk);
        vsync = 1'b1;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            if (frame_tick) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL frame_tick_timeout: got no tick, expected tick within 4 cycles");
        end else begin
            if (step_on_tick) step = 1'b1;
            @(negedge clk);
            step = 1'b0;
        end
    endtask

    task automatic pulse_step();
        @(negedge clk) step = 1'b1;
        @(negedge clk) step = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (text_y !== 10'd20) begin errors++; $display("FAIL reset_text_y: got %0d expected 20", text_y); end
        checks++; if (text_en !== 1'b1) begin errors++; $display("FAIL reset_text_en: got %b expected 1", text_en); end
        checks++; if (flash !== 1'b0) begin errors++; $display("FAIL reset_flash: got %b expected 0", flash); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
        checks++; if (ring_phase !== 8'd0) begin errors++; $display("FAIL reset_ring_phase: got %0d expected 0", ring_phase); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_frame_tick: got %b expected 0", frame_tick); end
    endtask

    task automatic test_frame_ticks();
        int t0, w0;
        do_reset();
        t0 = tick_count; w0 = wide_ticks;
        repeat (3) frame(1'b0);
        checks++; if (tick_count - t0 != 3) begin errors++; $display("FAIL tick_count: got %0d expected 3", tick_count - t0); end
        checks++; if (wide_ticks != w0) begin errors++; $display("FAIL tick_width: got %0d wide pulses expected 0", wide_ticks - w0); end
        checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL frame_cnt_3: got %0d expected 3", frame_cnt); end
        checks++; if (ring_phase !== 8'd3) begin errors++; $display("FAIL ring_phase_3: got %0d expected 3", ring_phase); end
        repeat (1000) @(negedge clk);
        checks++; if (tick_count - t0 != 3) begin errors++; $display("FAIL vsync_held_high: got %0d ticks expected 3", tick_count - t0); end
    endtask

    task automatic test_scene();
        logic [1:0] exp_st [13] = '{2'd0,2'd0,2'd0,2'd1,2'd1,2'd1,2'd2,2'd2,2'd3,2'd3,2'd3,2'd3,2'd0};
        logic [9:0] exp_y  [13] = '{10'd20,10'd20,10'd20,10'd20,10'd22,10'd24,10'd25,10'd25,10'd25,10'd25,10'd25,10'd25,10'd20};
        do_reset();
        for (int i = 0; i < 13; i++) begin
            frame(1'b0);
            checks++;
            if (state !== exp_st[i] || text_y !== exp_y[i] ||
                text_en !== (exp_st[i] <= 2'd1) || flash !== (exp_st[i] == 2'd2)) begin
                errors++;
                $display("FAIL scene_adv%0d: got st=%0d y=%0d en=%b fl=%b expected st=%0d y=%0d en=%b fl=%b",
                         i + 1, state, text_y, text_en, flash, exp_st[i], exp_y[i],
                         exp_st[i] <= 2'd1, exp_st[i] == 2'd2);
            end
        end
    endtask

    task automatic test_pause_step();
        do_reset();
        repeat (5) frame(1'b0);
        pause = 1'b1;
        repeat (5) frame(1'b0);
        checks++;
        if (frame_cnt !== 16'd5 || text_y !== 10'd22 || ring_phase !== 8'd5) begin
            errors++;
            $display("FAIL pause_hold: got cnt=%0d y=%0d ring=%0d expected cnt=5 y=22 ring=5", frame_cnt, text_y, ring_phase);
        end
        pulse_step();
        frame(1'b0);
        checks++;
        if (frame_cnt !== 16'd6 || text_y !== 10'd24 || ring_phase !== 8'd6) begin
            errors++;
            $display("FAIL single_step: got cnt=%0d y=%0d ring=%0d expected cnt=6 y=24 ring=6", frame_cnt, text_y, ring_phase);
        end
        frame(1'b0);
        checks++; if (frame_cnt !== 16'd6) begin errors++; $display("FAIL step_once: got %0d expected 6", frame_cnt); end
        pulse_step();
        pulse_step();
        frame(1'b0);
        checks++;
        if (frame_cnt !== 16'd7 || state !== 2'd2 || text_y !== 10'd25) begin
            errors++;
            $display("FAIL double_step: got cnt=%0d st=%0d y=%0d expected cnt=7 st=2 y=25", frame_cnt, state, text_y);
        end
        frame(1'b0);
        checks++; if (frame_cnt !== 16'd7) begin errors++; $display("FAIL double_step_collapse: got %0d expected 7", frame_cnt); end
        pause = 1'b0;
    endtask

    task automatic test_step_coincident();
        do_reset();
        pause = 1'b1;
        frame(1'b1);
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL coincident_step: got %0d expected 1", frame_cnt); end
        frame(1'b0);
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL coincident_no_pending: got %0d expected 1", frame_cnt); end
        pause = 1'b0;
    endtask

    task automatic test_speed();
        do_reset();
        speed = 2'd2;
        repeat (63) frame(1'b0);
        checks++; if (ring_phase !== 8'd252) begin errors++; $display("FAIL ring_252: got %0d expected 252", ring_phase); end
        frame(1'b0);
        checks++; if (ring_phase !== 8'd0) begin errors++; $display("FAIL ring_wrap: got %0d expected 0", ring_phase); end
        frame(1'b0);
        checks++; if (ring_phase !== 8'd4) begin errors++; $display("FAIL ring_after_wrap: got %0d expected 4", ring_phase); end
        speed = 2'd3;
        frame(1'b0);
        checks++;
        if (ring_phase !== 8'd4 || frame_cnt !== 16'd66) begin
            errors++;
            $display("FAIL ring_frozen: got ring=%0d cnt=%0d expected ring=4 cnt=66", ring_phase, frame_cnt);
        end
        speed = 2'd0;
    endtask

    task automatic test_reset_mid_fall();
        int t0;
        do_reset();
        repeat (6) frame(1'b0);
        checks++;
        if (state !== 2'd1 || text_y !== 10'd24) begin
            errors++;
            $display("FAIL pre_reset_fall: got st=%0d y=%0d expected st=1 y=24", state, text_y);
        end
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== 2'd0 || text_y !== 10'd20 || text_en !== 1'b1 || flash !== 1'b0 ||
            frame_cnt !== 16'd0 || ring_phase !== 8'd0 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL mid_fall_reset: got st=%0d y=%0d en=%b fl=%b cnt=%0d ring=%0d tick=%b expected 0 20 1 0 0 0 0",
                     state, text_y, text_en, flash, frame_cnt, ring_phase, frame_tick);
        end
        reset = 1'b0;
        t0 = tick_count;
        repeat (20) @(negedge clk);
        checks++; if (tick_count != t0) begin errors++; $display("FAIL no_spurious_tick: got %0d ticks expected 0", tick_count - t0); end
        frame(1'b0);
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL first_tick_after_reset: got %0d expected 1", frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_frame_ticks();
        test_scene();
        test_pause_step();
        test_step_coincident();
        test_speed();
        test_reset_mid_fall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
